// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the QPSK back-end frame synchroniser.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        PAYLOAD,
        CHECK
    } state_e;

    localparam int PAY_BITS = 40;
    localparam int HDR_BITS = 8;

    localparam logic [HDR_BITS-1:0] SYNC_WORD_DEF = 8'hA5;

endpackage

// File: rtl/bit_strobe_gen.sv
// Bit-timing generator: free-running sample counter, sampling instant and
// the registered one-cycle bit strobe that follows it.
module bit_strobe_gen #(
    parameter int SAMPLE    = 100,
    parameter int STB_PHASE = SAMPLE - 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic samp_o,
    output logic bit_stb_o
);

    localparam int            CW    = $clog2(SAMPLE);
    localparam logic [CW-1:0] LAST  = CW'(SAMPLE - 1);
    localparam logic [CW-1:0] PHASE = CW'(STB_PHASE);

    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic          bit_stb_q;

    assign samp_o    = en_i && (sample_cnt_q == PHASE);
    assign bit_stb_o = bit_stb_q;

    // Disabled counter parks at 0 so every enable starts from a known phase.
    always_comb begin
        sample_cnt_d = '0;
        if (en_i && (sample_cnt_q != LAST))
            sample_cnt_d = sample_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            bit_stb_q    <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            bit_stb_q    <= samp_o;
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchroniser: hunts for the sync header, captures 40-bit payload
// words and verifies every following header with flywheel tolerance.
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int                   SAMPLE    = 100,
    parameter int                   STB_PHASE = SAMPLE - 3,
    parameter logic [HDR_BITS-1:0]  SYNC_WORD = SYNC_WORD_DEF,
    parameter int                   MISS_MAX  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                ser_i,
    output logic                bit_stb,
    output logic                locked,
    output logic [PAY_BITS-1:0] para_o,
    output logic                para_vld,
    output logic                sync_err
);

    localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);
    localparam logic [5:0] PAY_LAST = 6'(PAY_BITS - 1);
    localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);

    state_e                state_q;
    logic [HDR_BITS-1:0]   sync_sr_q, sync_sr_d;
    logic [PAY_BITS-1:0]   pay_sr_q, pay_sr_d;
    logic [PAY_BITS-1:0]   para_q;
    logic [5:0]            bit_cnt_q;
    logic [3:0]            miss_cnt_q, miss_cnt_d;
    logic                  locked_q, para_vld_q, sync_err_q;
    logic                  samp;

    bit_strobe_gen #(
        .SAMPLE    (SAMPLE),
        .STB_PHASE (STB_PHASE)
    ) u_stb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .samp_o    (samp),
        .bit_stb_o (bit_stb)
    );

    assign sync_sr_d  = {sync_sr_q[HDR_BITS-2:0], ser_i};
    assign pay_sr_d   = {pay_sr_q[PAY_BITS-2:0], ser_i};
    assign miss_cnt_d = miss_cnt_q + 4'd1;

    assign locked   = locked_q;
    assign para_o   = para_q;
    assign para_vld = para_vld_q;
    assign sync_err = sync_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_sr_q  <= '0;
            pay_sr_q   <= '0;
            para_q     <= '0;
            bit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            locked_q   <= 1'b0;
            para_vld_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            para_vld_q <= 1'b0;
            sync_err_q <= 1'b0;
            if (!en) begin
                // Partial word is abandoned; para_q keeps the last full word.
                state_q    <= IDLE;
                sync_sr_q  <= '0;
                bit_cnt_q  <= '0;
                miss_cnt_q <= '0;
                locked_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= HUNT;
                    HUNT: if (samp) begin
                        sync_sr_q <= sync_sr_d;
                        if (sync_sr_d == SYNC_WORD) begin
                            state_q    <= PAYLOAD;
                            locked_q   <= 1'b1;
                            bit_cnt_q  <= '0;
                            miss_cnt_q <= '0;
                        end
                    end
                    PAYLOAD: if (samp) begin
                        pay_sr_q <= pay_sr_d;
                        if (bit_cnt_q == PAY_LAST) begin
                            state_q    <= CHECK;
                            bit_cnt_q  <= '0;
                            para_q     <= pay_sr_d;
                            para_vld_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                    CHECK: if (samp) begin
                        sync_sr_q <= sync_sr_d;
                        if (bit_cnt_q == HDR_LAST) begin
                            bit_cnt_q <= '0;
                            if (sync_sr_d == SYNC_WORD) begin
                                miss_cnt_q <= '0;
                                state_q    <= PAYLOAD;
                            end else begin
                                sync_err_q <= 1'b1;
                                miss_cnt_q <= miss_cnt_d;
                                // Too many consecutive misses: drop lock and re-hunt.
                                if (miss_cnt_d == MISS_LIM) begin
                                    state_q   <= HUNT;
                                    sync_sr_q <= '0;
                                    locked_q  <= 1'b0;
                                end else begin
                                    state_q <= PAYLOAD;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Scoreboard bench for frame_sync_ctrl: per-bit expectations from a stream
// model are queued by the driver and checked on every bit strobe.
module tb_frame_sync_ctrl;

    localparam int          SAMPLE    = 20;
    localparam int          STB_PHASE = SAMPLE - 3;
    localparam int          MISS_MAX  = 3;
    localparam logic [7:0]  SYNC      = 8'hA5;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, ser_i = 1'b0;
    logic        bit_stb, locked, para_vld, sync_err;
    logic [39:0] para_o;

    frame_sync_ctrl #(
        .SAMPLE(SAMPLE), .STB_PHASE(STB_PHASE), .SYNC_WORD(SYNC), .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ser_i(ser_i), .bit_stb(bit_stb),
        .locked(locked), .para_o(para_o), .para_vld(para_vld), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          lk;
        bit          pv;
        bit          se;
        logic [39:0] po;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: hunting with an 8-bit window, or locked at a position
    // 0..47 inside a 48-bit frame (40 payload bits then 8 header bits).
    bit          m_lock;
    logic [7:0]  m_win;
    int          m_pos, m_miss;
    logic [39:0] m_word, m_para;

    task automatic model_clear(bit clr_para);
        m_lock = 0; m_win = '0; m_pos = 0; m_miss = 0;
        if (clr_para) m_para = '0;
    endtask

    task automatic model_bit(bit b);
        exp_t e;
        e.pv = 0; e.se = 0;
        if (!m_lock) begin
            m_win = {m_win[6:0], b};
            if (m_win == SYNC) begin m_lock = 1; m_pos = 0; m_miss = 0; end
        end else if (m_pos < 40) begin
            m_word = {m_word[38:0], b};
            m_pos++;
            if (m_pos == 40) begin m_para = m_word; e.pv = 1; end
        end else begin
            m_win = {m_win[6:0], b};
            m_pos++;
            if (m_pos == 48) begin
                m_pos = 0;
                if (m_win == SYNC) m_miss = 0;
                else begin
                    e.se = 1;
                    m_miss++;
                    if (m_miss == MISS_MAX) begin m_lock = 0; m_win = '0; end
                end
            end
        end
        e.lk = m_lock; e.po = m_para;
        q.push_back(e);
    endtask

    // Monitor: one expectation per strobe; pulses outside strobes are stray.
    int   cyc = 0, last_stb = -1;
    exp_t me;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n || !en) last_stb = -1;
        else if (bit_stb) begin
            if (last_stb >= 0) chk("stb_period", 64'(cyc - last_stb), 64'(SAMPLE));
            last_stb = cyc;
        end
        if (rst_n && bit_stb) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_stb: got bit_stb=1 expected no strobe at %0t", $time);
            end else begin
                me = q.pop_front();
                chk("locked",   64'(locked),   64'(me.lk));
                chk("para_vld", 64'(para_vld), 64'(me.pv));
                chk("sync_err", 64'(sync_err), 64'(me.se));
                chk("para_o",   64'(para_o),   64'(me.po));
            end
        end else if (rst_n && (para_vld || sync_err)) begin
            chk("stray_pulse", 64'({para_vld, sync_err}), 64'(0));
        end
    end

    bit first = 0;

    task automatic send_bit(bit b);
        ser_i = b;
        model_bit(b);
        repeat (first ? STB_PHASE + 1 : SAMPLE) @(posedge clk);
        first = 0;
        @(negedge clk);
    endtask

    task automatic send_bits(logic [63:0] v, int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(logic [7:0] hdr, logic [39:0] w);
        send_bits(64'(hdr), 8);
        send_bits(64'(w), 40);
    endtask

    task automatic start_en();
        repeat (3) @(negedge clk);
        en = 1; first = 1;
    endtask

    task automatic abort_en();
        en = 0;
        model_clear(0);
        repeat (4) @(negedge clk);
        chk("abort_locked", 64'(locked), 64'(0));
        chk("abort_para_o", 64'(para_o), 64'(m_para));
    endtask

    function automatic logic [39:0] rword();
        return {8'($urandom), 32'($urandom)};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        model_clear(1);
        m_word = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({bit_stb, locked, para_vld, sync_err, para_o}), 64'(0));
        rst_n = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_outs", 64'({bit_stb, locked, para_vld, sync_err, para_o}), 64'(0));
        end

        // Acquisition after a false byte.
        start_en();
        send_bits(64'h3C, 8);
        send_frame(SYNC, 40'h123456789A);
        send_frame(SYNC, rword());
        send_frame(SYNC, rword());

        // Flywheel: isolated misses, good header in between resets the count.
        send_frame(8'hA4, rword());
        send_frame(SYNC,  rword());
        send_frame(8'h25, rword());
        send_frame(8'hE5, rword());
        send_frame(SYNC,  rword());

        // Loss of lock after three consecutive misses, then re-acquire.
        send_frame(8'h00, rword());
        send_frame(8'hFF, rword());
        send_frame(8'h5A, 40'h0);
        send_bits(64'h0, 8);
        send_frame(SYNC, rword());
        send_frame(SYNC, rword());

        // Mid-frame abort via en.
        send_bits(64'(SYNC), 8);
        send_bits(64'(rword()), 20);
        abort_en();

        // Straddling pattern: only the full alignment locks.
        start_en();
        send_bits(64'hA4A5, 16);
        send_bits(64'(rword()), 40);
        send_frame(SYNC, rword());

        // Mid-frame abort via reset.
        send_bits(64'(SYNC), 8);
        send_bits(64'(rword()), 20);
        rst_n = 0;
        model_clear(1);
        repeat (3) @(negedge clk);
        chk("rst_para_o", 64'(para_o), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        rst_n = 1; first = 1;
        send_bits(64'(SYNC), 8);
        send_bits(64'(rword()), 40);

        // Randomised frames with occasional corrupted headers.
        for (int f = 0; f < 12; f++) begin
            logic [7:0] h;
            h = SYNC;
            if ($urandom_range(3) == 0) h = SYNC ^ (8'h1 << $urandom_range(7));
            send_frame(h, rword());
        end

        en = 0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
# frame_sync_ctrl

Bit-timing and frame-alignment controller for the QPSK demodulator back end. It sits between the demodulator's serial decision output and the payload consumers. It generates the per-bit sampling strobe from the sample-rate clock and hunts for an 8-bit sync header. Once aligned, it sequences capture of fixed 40-bit payload words, then checks the header of every following frame, with flywheel tolerance for isolated header errors.

## Interface
- SAMPLE, 100: clk cycles per bit (≥4).
- STB_PHASE, SAMPLE-3: sample_cnt value at which ser_i is sampled (0..SAMPLE-1).
- SYNC_WORD, 8'hA5: header pattern, MSB received first.
- MISS_MAX, 3: consecutive header mismatches that drop lock (1..15).

- clk  in  1  sample-rate clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  level enable. 0 forces IDLE.
- ser_i  in  1  demodulated serial bit, constant for SAMPLE cycles
- bit_stb  out  1  one-cycle pulse, registered, one cycle after each sampling instant
- locked  out  1  high while in PAYLOAD or CHECK
- para_o  out  40  last completed payload word; bit 39 is the first received bit
- para_vld  out  1  one-cycle pulse when para_o updates
- sync_err  out  1  one-cycle pulse on a header mismatch in CHECK

## Operation
- sample_cnt is $clog2(SAMPLE) bits wide and free-runs 0..SAMPLE-1 while en=1. It is held at 0 while en=0.
- Sampling instant: sample_cnt==STB_PHASE with en=1. All shift/count/state actions below occur only at sampling instants.
- States:
  - IDLE (reset): entered whenever en=0, from any state, on the next edge. Clears sync_sr, bit_cnt and miss_cnt. For en=1 → HUNT.
  - HUNT: sync_sr <= {sync_sr[6:0], ser_i}. If the new value equals SYNC_WORD → PAYLOAD, bit_cnt=0, miss_cnt=0.
  - PAYLOAD: pay_sr <= {pay_sr[38:0], ser_i}, bit_cnt++. On the 40th bit (bit_cnt==39) → CHECK, bit_cnt=0. On the next cycle, para_o takes the full 40 bits and para_vld pulses.
  - CHECK: shift into sync_sr, bit_cnt++. On the 8th bit:
    - Match: miss_cnt=0, → PAYLOAD.
    - Mismatch: sync_err pulses and miss_cnt++. If the new miss_cnt == MISS_MAX → HUNT with sync_sr cleared. Otherwise → PAYLOAD (flywheel).
- HUNT accepts overlapping matches, so sync_sr is never cleared in HUNT.
- Reset values: bit_stb=0, locked=0, para_o=0, para_vld=0, sync_err=0, state=IDLE, all counters 0.
- Reset mid-frame discards the partial word. para_o goes to 0.
- en deasserted mid-PAYLOAD drops the partial word without a para_vld pulse. para_o keeps its last value.
- para_o changes only with para_vld. It is never partially updated.

## Timing
- bit_stb: asserted at the edge after each sampling instant, one cycle wide. Period is SAMPLE cycles.
- para_vld: asserted 1 cycle after the sampling instant of payload bit 40. It is coincident with the bit_stb of that bit.
- sync_err: asserted 1 cycle after the 8th CHECK sampling instant.
- locked rises with the first PAYLOAD cycle, i.e. 1 cycle after the matching HUNT sample. It falls 1 cycle after the failing CHECK sample.
- Frame period when locked: 48 bits = 48·SAMPLE cycles. Consecutive para_vld pulses are exactly 48·SAMPLE cycles apart.
- No backpressure. A consumer must latch para_o within 48·SAMPLE cycles.

## Structure
- Package frame_sync_pkg:
  - State enum: IDLE, HUNT, PAYLOAD, CHECK.
  - Constants: PAY_BITS=40, HDR_BITS=8.
  - Default SYNC_WORD.
- One sub-module, bit_strobe_gen, holds sample_cnt and the sampling-instant/bit_stb logic. It is parameterised by SAMPLE and STB_PHASE.
- The FSM, shift registers and counters live in the top level.

## Test plan
- Reset/idle: rst_n low, then en=0 for 1000 cycles → all outputs 0, no bit_stb.
- Acquisition: SAMPLE=100, stream 0x3C, 0xA5, 40-bit 0x123456789A, 0xA5, … → locked rises after the A5, para_o=0x123456789A with one para_vld, sync_err never asserts, bit_stb period exactly 100.
- Flywheel: locked, corrupt one header to 0xA4 → one sync_err pulse, locked stays 1, next payload still delivered, the following good header resets miss_cnt.
- Loss of lock: MISS_MAX=3, three consecutive bad headers → three sync_err pulses, locked falls after the third; a later 0xA5 re-acquires.
- Overlap/false start: bits …1010_0101… embedded as 0x4A5 preceded by 0xA (pattern straddling) → lock on the first full 0xA5 alignment only.
- Mid-frame abort: drop en after 20 payload bits, reassert → no para_vld for the partial word, para_o unchanged, FSM back in HUNT. Repeat the test with an rst_n pulse instead of en → para_o=0.
